// File: rtl/plca_pkg.sv
// Shared definitions for the PLCA status controller: state encoding,
// default timing constants and a state-to-status helper.
package plca_pkg;

  // State encoding, also driven out on the state port.
  localparam logic [1:0] DISABLED   = 2'd0;
  localparam logic [1:0] INACTIVE   = 2'd1;
  localparam logic [1:0] ACTIVE     = 2'd2;
  localparam logic [1:0] HYSTERESIS = 2'd3;

  // Defaults for a 25 MHz clock.
  localparam int STATUS_CYCLES_DEF = 3253;  // 130090 ns, rounded up
  localparam int HYST_CYCLES_DEF   = 250;   // 10000 ns
  localparam int CNT_W_DEF         = 16;

  // plca_status is OK in ACTIVE and in HYSTERESIS.
  function automatic logic status_of(input logic [1:0] st);
    status_of = (st == ACTIVE) || (st == HYSTERESIS);
  endfunction

endpackage

// File: rtl/plca_down_counter.sv
// Loadable down counter with synchronous clear and a zero flag.
// Decrement saturates at zero so the count never wraps.
module plca_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins over load, load wins over decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/plca_status_ctrl.sv
// PLCA status controller: tracks BEACON activity and reports plca_status.
// Optional feature macro: PLCA_STATUS_HYST_EN adds the HYSTERESIS state,
// which holds plca_status OK for HYST_CYCLES after the status timer expires.
// Without it, ACTIVE expiry returns straight to INACTIVE.
module plca_status_ctrl
  import plca_pkg::*;
#(
  parameter int STATUS_CYCLES = STATUS_CYCLES_DEF,
  parameter int HYST_CYCLES   = HYST_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       plca_en,
  input  logic       plca_reset,
  input  logic       beacon_rx,
  input  logic       beacon_tx,
  output logic       plca_status,
  output logic       status_timer_done,
  output logic       status_timer_not_done,
  output logic [1:0] state,
  output logic       status_chg
);

  // Timing parameters must fit the counter and be non-zero.
  if ((STATUS_CYCLES < 32'sd1) || (64'(STATUS_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_status
    $error("plca_status_ctrl: STATUS_CYCLES out of range for CNT_W");
  end
  if ((HYST_CYCLES < 32'sd1) || (64'(HYST_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_hyst
    $error("plca_status_ctrl: HYST_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] STATUS_LOAD = CNT_W'(STATUS_CYCLES - 1);
`ifdef PLCA_STATUS_HYST_EN
  localparam logic [CNT_W-1:0] HYST_LOAD   = CNT_W'(HYST_CYCLES - 1);
`endif

  logic [1:0]       rst_sync_r;
  logic             run_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             plca_status_r;
  logic             done_r;
  logic             not_done_r;
  logic             status_chg_r;
  logic             beacon_s;
  logic             abort_s;
  logic             done_nxt_s;
  logic             cnt_clr_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;

  // Two-flop reset release: logic stays idle until both flops are set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign run_s = rst_sync_r[1];

  // Shared timer for the status and hysteresis phases.
  plca_down_counter #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state and timer control; disable/soft reset beats beacon and expiry.
  always_comb begin
    beacon_s       = beacon_rx | beacon_tx;
    abort_s        = ~plca_en | plca_reset;
    state_nxt_s    = state_r;
    cnt_clr_s      = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = STATUS_LOAD;
    cnt_dec_s      = 1'b0;
    done_nxt_s     = 1'b0;
    if (!run_s) begin
      state_nxt_s = DISABLED;
      cnt_clr_s   = 1'b1;
    end else begin
      case (state_r)
        DISABLED: begin
          cnt_clr_s = 1'b1;
          if (!abort_s) begin
            state_nxt_s = INACTIVE;
          end else begin
            state_nxt_s = DISABLED;
          end
        end
        INACTIVE: begin
          if (abort_s) begin
            state_nxt_s = DISABLED;
            cnt_clr_s   = 1'b1;
          end else if (beacon_s) begin
            state_nxt_s = ACTIVE;
            cnt_load_s  = 1'b1;
          end else begin
            state_nxt_s = INACTIVE;
          end
        end
        ACTIVE: begin
          if (abort_s) begin
            state_nxt_s = DISABLED;
            cnt_clr_s   = 1'b1;
          end else if (beacon_s) begin
            state_nxt_s = ACTIVE;
            cnt_load_s  = 1'b1;
          end else if (cnt_zero_s) begin
            done_nxt_s = 1'b1;
`ifdef PLCA_STATUS_HYST_EN
            state_nxt_s    = HYSTERESIS;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = HYST_LOAD;
`else
            state_nxt_s = INACTIVE;
            cnt_clr_s   = 1'b1;
`endif
          end else begin
            state_nxt_s = ACTIVE;
            cnt_dec_s   = 1'b1;
          end
        end
`ifdef PLCA_STATUS_HYST_EN
        HYSTERESIS: begin
          if (abort_s) begin
            state_nxt_s = DISABLED;
            cnt_clr_s   = 1'b1;
          end else if (beacon_s) begin
            state_nxt_s = ACTIVE;
            cnt_load_s  = 1'b1;
          end else if (cnt_zero_s) begin
            state_nxt_s = INACTIVE;
            cnt_clr_s   = 1'b1;
          end else begin
            state_nxt_s = HYSTERESIS;
            cnt_dec_s   = 1'b1;
          end
        end
`endif
        default: begin
          state_nxt_s = DISABLED;
          cnt_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= DISABLED;
      plca_status_r <= 1'b0;
      done_r        <= 1'b0;
      not_done_r    <= 1'b0;
      status_chg_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      plca_status_r <= status_of(state_nxt_s);
      done_r        <= done_nxt_s;
      not_done_r    <= (state_nxt_s == ACTIVE);
      status_chg_r  <= (status_of(state_nxt_s) != plca_status_r);
    end
  end

  assign state                 = state_r;
  assign plca_status           = plca_status_r;
  assign status_timer_done     = done_r;
  assign status_timer_not_done = not_done_r;
  assign status_chg            = status_chg_r;

endmodule

// File: tb/tb_plca_status_ctrl.sv
// Scoreboard bench for plca_status_ctrl. The reference model works with
// absolute deadlines (edge index of expiry) rather than a counter and pushes
// one expected record per output event; the monitor pops on DUT events.
module tb_plca_status_ctrl;

  localparam int S = 3253;
  localparam int H = 250;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       plca_en = 1'b0;
  logic       plca_reset = 1'b0;
  logic       beacon_rx = 1'b0;
  logic       beacon_tx = 1'b0;
  logic       plca_status;
  logic       status_timer_done;
  logic       status_timer_not_done;
  logic [1:0] state;
  logic       status_chg;

  plca_status_ctrl dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .plca_en               (plca_en),
    .plca_reset            (plca_reset),
    .beacon_rx             (beacon_rx),
    .beacon_tx             (beacon_tx),
    .plca_status           (plca_status),
    .status_timer_done     (status_timer_done),
    .status_timer_not_done (status_timer_not_done),
    .state                 (state),
    .status_chg            (status_chg)
  );

  always #20 clk = ~clk;

  typedef struct {
    int edge_n;
    int st;
    bit status;
    bit done;
    bit chg;
    bit notdone;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  edge_cnt = 0;
  int  done_seen = 0;

  // model state: 0 disabled, 1 inactive, 2 active, 3 hysteresis
  int  m_mode = 0;
  int  m_deadline = 0;
  int  m_hold = 0;
  bit  m_status = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour for the clock edge with index n.
  task automatic model_step(input int n, input bit en, input bit prst, input bit bcn);
    int nm;
    bit dn;
    bit ns;
    nm = m_mode;
    dn = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
      return;
    end
    if (m_mode != 0 && (!en || prst)) begin
      nm = 0;
    end else begin
      case (m_mode)
        0: if (en && !prst) nm = 1;
        1: if (bcn) begin nm = 2; m_deadline = n + S; end
        2: begin
          if (bcn) m_deadline = n + S;
          else if (n == m_deadline) begin
            dn = 1'b1;
`ifdef PLCA_STATUS_HYST_EN
            nm = 3;
            m_deadline = n + H;
`else
            nm = 1;
`endif
          end
        end
        3: begin
          if (bcn) begin nm = 2; m_deadline = n + S; end
          else if (n == m_deadline) nm = 1;
        end
        default: nm = 0;
      endcase
    end
    ns = (nm == 2) || (nm == 3);
    if (nm != m_mode || dn || ns != m_status)
      exp_q.push_back('{n, nm, ns, dn, (ns != m_status), (nm == 2)});
    m_mode = nm;
    m_status = ns;
  endtask

  task automatic drive(input bit en, input bit prst, input bit brx, input bit btx);
    @(negedge clk);
    plca_en = en;
    plca_reset = prst;
    beacon_rx = brx;
    beacon_tx = btx;
    model_step(edge_cnt + 1, en, prst, brx | btx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_status"}, plca_status, 0);
    chk({tag, "_done"}, status_timer_done, 0);
    chk({tag, "_not_done"}, status_timer_not_done, 0);
    chk({tag, "_chg"}, status_chg, 0);
  endtask

  task automatic do_reset(input int hold_cycles);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    plca_en = 1'b0;
    plca_reset = 1'b0;
    beacon_rx = 1'b0;
    beacon_tx = 1'b0;
    #1;
    chk_all_zero("rst_now");
    m_mode = 0;
    m_status = 1'b0;
    repeat (hold_cycles) @(negedge clk);
    chk_all_zero("rst_hold");
    reset_n = 1'b1;
    m_hold = 2;
    model_step(edge_cnt + 1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops an expected record whenever the DUT shows an output event.
  initial begin
    int prev_st;
    ev_t e;
    prev_st = 0;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_event: nothing seen at edge %0d, expected state %0d status %0b done %0b",
                 e.edge_n, e.st, e.status, e.done);
      end
      if (status_timer_done) done_seen++;
      if (!reset_n) begin
        prev_st = 0;
      end else if (state != prev_st || status_timer_done || status_chg) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: edge %0d state %0d status %0b done %0b chg %0b, expected no event",
                   edge_cnt, state, plca_status, status_timer_done, status_chg);
        end else begin
          e = exp_q.pop_front();
          if (e.edge_n != edge_cnt || e.st != int'(state) || e.status != plca_status ||
              e.done != status_timer_done || e.chg != status_chg || e.notdone != status_timer_not_done) begin
            n_fail++;
            $display("FAIL event: edge %0d st %0d sts %0b dn %0b chg %0b nd %0b; expected edge %0d st %0d sts %0b dn %0b chg %0b nd %0b",
                     edge_cnt, state, plca_status, status_timer_done, status_chg, status_timer_not_done,
                     e.edge_n, e.st, e.status, e.done, e.chg, e.notdone);
          end
        end
        prev_st = int'(state);
      end
    end
  end

  initial begin
    int d0;
    bit en_v;
    bit [1:0] sel;
    #1;
    chk_all_zero("por");
    do_reset(4);

    // Enabled but silent: INACTIVE, status FAIL.
    idle(10000);
    chk("quiet_state", state, 1);
    chk("quiet_status", plca_status, 0);

    // Single beacon_rx: status up next edge, expiry S cycles later.
    d0 = done_seen;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("beacon_status", plca_status, 1);
    chk("beacon_chg", status_chg, 1);
    chk("beacon_not_done", status_timer_not_done, 1);
    idle(S + H + 5);
    chk("single_done_count", done_seen - d0, 1);
    chk("single_end_state", state, 1);

    // beacon_tx every 3000 cycles for 20 periods.
    d0 = done_seen;
    for (int p = 0; p < 20; p++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      idle(2999);
      chk("periodic_status", plca_status, 1);
    end
    chk("periodic_no_done", done_seen - d0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Both beacons at once, then a beacon exactly at count zero.
    d0 = done_seen;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    idle(S - 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("zero_beacon_state", state, 2);
    chk("zero_beacon_done", status_timer_done, 0);

    // Reset while ACTIVE with count 1000: no expiry may follow.
    idle(2251);
    do_reset(3);
    idle(1200);
    chk("reset_no_done", done_seen - d0, 0);
    chk("reset_state", state, 1);

    // Soft reset together with a beacon.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef PLCA_STATUS_HYST_EN
    idle(S + 10);
    chk("in_hyst_state", state, 3);
`else
    idle(100);
    chk("in_active_state", state, 2);
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("prst_state", state, 0);
    chk("prst_status", plca_status, 0);
    chk("prst_chg", status_chg, 1);
    idle(5);

    // Random traffic.
    en_v = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 599) == 0) en_v = ~en_v;
      sel = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 149) == 0)
        drive(en_v, ($urandom_range(0, 399) == 0), sel[0], sel[1]);
      else
        drive(en_v, ($urandom_range(0, 399) == 0), 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plca_status_ctrl.md
PLCA_STATUS_CTRL -- requirements
Module: plca_status_ctrl

Interface
REQ-001 Parameter STATUS_CYCLES, default 3253: plca_status_timer length in clk cycles (130090 ns at 25 MHz, rounded up).
REQ-002 Parameter HYST_CYCLES, default 250: hysteresis length in clk cycles (10000 ns at 25 MHz).
REQ-003 Parameter CNT_W, default 16: timer counter width.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 plca_en  input  1  PLCA enabled (level).
REQ-007 plca_reset  input  1  synchronous PLCA soft reset (level).
REQ-008 beacon_rx  input  1  one-cycle pulse, rx_cmd = BEACON detected.
REQ-009 beacon_tx  input  1  one-cycle pulse, local coordinator transmitted a BEACON.
REQ-010 plca_status  output  1  1 = OK, 0 = FAIL.
REQ-011 status_timer_done  output  1  one-cycle pulse on status-timer expiry.
REQ-012 status_timer_not_done  output  1  status timer running.
REQ-013 state  output  2  encoded state: 0 DISABLED, 1 INACTIVE, 2 ACTIVE, 3 HYSTERESIS.
REQ-014 status_chg  output  1  one-cycle pulse when plca_status changes value.

Function
REQ-015 beacon = beacon_rx OR beacon_tx; both asserted in one cycle count as one beacon.
REQ-016 DISABLED: plca_status 0; timer cleared; go to INACTIVE when plca_en=1 and plca_reset=0.
REQ-017 INACTIVE: plca_status 0; on beacon, load the counter with STATUS_CYCLES-1 and go to ACTIVE.
REQ-018 ACTIVE: plca_status 1; the counter decrements once per cycle; a beacon reloads STATUS_CYCLES-1 with no expiry in that cycle.
REQ-019 ACTIVE expiry: when the counter is 0 with no beacon, pulse status_timer_done and go to HYSTERESIS, or to INACTIVE when hysteresis is compiled out.
REQ-020 HYSTERESIS: plca_status stays 1; the counter is loaded with HYST_CYCLES-1 on entry; a beacon returns to ACTIVE with a reload; at count 0 with no beacon, go to INACTIVE.
REQ-021 From INACTIVE, ACTIVE or HYSTERESIS, plca_en=0 or plca_reset=1 goes to DISABLED next cycle and takes priority over beacon and expiry.
REQ-022 Latency: a beacon in INACTIVE sets plca_status=1 on the next clk edge; the ACTIVE-to-INACTIVE path with no hysteresis drops plca_status exactly STATUS_CYCLES cycles after the last beacon.
REQ-023 status_timer_not_done=1 only in ACTIVE; it is 0 in the expiry cycle's next state.
REQ-024 Counter arithmetic: unsigned CNT_W bits, never wraps; STATUS_CYCLES and HYST_CYCLES must be >=1 and <2^CNT_W (elaboration check in simulation).
REQ-025 All outputs are registered; no combinational input-to-output paths.

Reset
REQ-026 reset_n low: state DISABLED, counter 0, plca_status 0, status_timer_done 0, status_timer_not_done 0, status_chg 0, all immediately (asynchronous).
REQ-027 Reset deassertion is synchronised internally with a two-flop release; the first state transition occurs no earlier than the second clk edge after release.
REQ-028 Reset mid-ACTIVE discards the timer; no status_timer_done pulse is produced.

Configuration
REQ-029 Macro PLCA_STATUS_HYST_EN: when defined, HYSTERESIS state and HYST_CYCLES are implemented.
REQ-030 Without PLCA_STATUS_HYST_EN: the HYSTERESIS encoding is unreachable; ACTIVE expiry goes directly to INACTIVE, and plca_status falls in the same edge as the status_timer_done pulse.

Structure
REQ-031 Shared package plca_pkg holds the state encoding constants (DISABLED, INACTIVE, ACTIVE, HYSTERESIS) and the default cycle constants.
REQ-032 One sub-module, plca_down_counter: a loadable, synchronous-clear down counter with a zero flag, instantiated once and shared between the status and hysteresis phases.

Verification
REQ-033 Reset, then plca_en=1 with no beacons for 10000 cycles -> state=1, plca_status=0, no status_chg.
REQ-034 Single beacon_rx -> plca_status=1 next edge with status_chg; status_timer_done exactly 3253 cycles later; with hysteresis, plca_status=0 250 cycles after that.
REQ-035 beacon_tx every 3000 cycles for 20 periods -> plca_status stays 1 and status_timer_done never pulses.
REQ-036 Beacon in the same cycle the counter reaches 0 -> reload, no expiry pulse, state stays ACTIVE.
REQ-037 plca_reset=1 while in HYSTERESIS at the same time as a beacon -> state=0 next edge, plca_status=0, status_chg pulse.
REQ-038 reset_n asserted mid-ACTIVE at count 1000 -> all outputs 0 immediately and no later status_timer_done; repeat REQ-034 with PLCA_STATUS_HYST_EN undefined.
